// File: rtl/sisc_prog_loader.sv
// Program loader for the SISC core: turns a length-prefixed byte stream into
// 32-bit IM writes and releases the core from reset once the image is complete.
module sisc_prog_loader #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [7:0]        BYTE_IN,
  input  logic              BYTE_VALID,
  output logic              BYTE_READY,
  output logic              IM_WE,
  output logic [ADDR_W-1:0] IM_ADDR,
  output logic [31:0]       IM_WDATA,
  output logic              CORE_RST_F,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR,
  output logic [ADDR_W-1:0] WORD_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       shift_q, shift_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              byte_ready_q, byte_ready_d;
  logic              im_we_q, im_we_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              core_rst_f_q, core_rst_f_d;
  logic              accept;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      word_cnt_q   <= '0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      core_rst_f_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      word_cnt_q   <= word_cnt_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      byte_ready_q <= byte_ready_d;
      im_we_q      <= im_we_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      core_rst_f_q <= core_rst_f_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    accept     = BYTE_VALID && byte_ready_q;

    case (state_q)
      S_IDLE: begin
        if (START) state_d = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (accept) begin
          len_d   = {BYTE_IN, len_q[7:0]};
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          len_d      = {len_q[15:8], BYTE_IN};
          idx_d      = '0;
          word_cnt_d = '0;
          if (len_d == 16'd0)                       state_d = S_DONE;
          else if ({16'd0, len_d} > 32'(MAX_WORDS)) state_d = S_ERR;
          else                                      state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d = {shift_q[23:0], BYTE_IN};
          if (idx_q == 2'd3) begin
            idx_d      = '0;
            im_addr_d  = BASE_ADDR + word_cnt_q;
            im_wdata_d = shift_d;
            state_d    = S_WRITE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + ADDR_W'(1);
        idx_d      = '0;
        if (32'(word_cnt_d) == 32'(len_q)) state_d = S_DONE;
        else                               state_d = S_DATA;
      end
      S_DONE, S_ERR: begin
        if (START) begin
          len_d      = '0;
          word_cnt_d = '0;
          idx_d      = '0;
          state_d    = S_HDR_HI;
        end
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) || (state_d == S_DATA);
    im_we_d      = (state_d == S_WRITE);
    // Status flags lag entry into DONE/ERR by one cycle but drop on the restart edge.
    load_done_d  = (state_q == S_DONE) && (state_d == S_DONE);
    load_err_d   = (state_q == S_ERR) && (state_d == S_ERR);
    core_rst_f_d = load_done_d;
  end

  assign BYTE_READY = byte_ready_q;
  assign IM_WE      = im_we_q;
  assign IM_ADDR    = im_addr_q;
  assign IM_WDATA   = im_wdata_q;
  assign CORE_RST_F = core_rst_f_q;
  assign LOAD_DONE  = load_done_q;
  assign LOAD_ERR   = load_err_q;
  assign WORD_CNT   = word_cnt_q;

endmodule

// File: doc/sisc_prog_loader.md
Name: sisc_prog_loader

Overview:
Upstream of the SISC core. Receives a program image as a byte stream and assembles it into 32-bit instruction words. Writes those words into instruction memory, then releases the core from reset. Holds the core in reset (CORE_RST_F low) for the whole load, so the core never fetches from a partially written IM.

Parameters:
ADDR_W, 16, IM word-address width (matches PC width)
BASE_ADDR, 0, IM word address of the first loaded word
MAX_WORDS, 1024, largest legal image length in words

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST  in  1  asynchronous active-high reset
START  in  1  single-cycle pulse that begins a load
BYTE_IN  in  8  stream data byte
BYTE_VALID  in  1  BYTE_IN valid this cycle
BYTE_READY  out  1  loader accepts a byte this cycle
IM_WE  out  1  IM write strobe, one cycle per word
IM_ADDR  out  ADDR_W  IM write word address
IM_WDATA  out  32  IM write data
CORE_RST_F  out  1  active-low reset to the SISC core
LOAD_DONE  out  1  image fully written
LOAD_ERR  out  1  header length illegal
WORD_CNT  out  ADDR_W  words written so far in the current load

Behaviour:
- Reset (asynchronous, RST=1): state IDLE. All of the following are 0: BYTE_READY, IM_WE, IM_ADDR, IM_WDATA, LOAD_DONE, LOAD_ERR, WORD_CNT, CORE_RST_F, the byte index and the length register.
- Handshake: a byte transfers only on a rising edge where BYTE_VALID=1 and BYTE_READY=1. BYTE_READY is a registered function of state:
  - 1 in HDR_HI, HDR_LO, DATA;
  - 0 in all other states.
  - With BYTE_VALID=0 the state holds (stalls are unbounded).
- States:
  - IDLE: START -> HDR_HI.
  - HDR_HI: accept byte -> LEN[15:8]; go to HDR_LO.
  - HDR_LO: accept byte -> LEN[7:0]; then:
    - LEN=0 -> DONE;
    - LEN>MAX_WORDS -> ERR;
    - otherwise -> DATA with byte index 0 and WORD_CNT 0.
  - DATA: accept bytes big-endian into a 32-bit shift register (first byte -> bits 31:24). Index counts 0..3. Accepting the byte at index 3 -> WRITE.
  - WRITE (exactly one cycle): IM_WE=1, IM_ADDR=BASE_ADDR+WORD_CNT, IM_WDATA=assembled word, BYTE_READY=0. Next edge: WORD_CNT+1 and index cleared. If new WORD_CNT==LEN -> DONE, else -> DATA.
  - DONE: LOAD_DONE=1, CORE_RST_F=1. Both are registered, so they rise the cycle after DONE is entered. Extra stream bytes are not accepted.
  - ERR: LOAD_ERR=1, CORE_RST_F stays 0, no IM writes.
- Registered-output latency: IM_WE/IM_ADDR/IM_WDATA are valid during the WRITE cycle. IM_WE is 0 in every other state.
- START rules:
  - Ignored in HDR_HI, HDR_LO, DATA, WRITE.
  - In DONE or ERR, START restarts the load: -> HDR_HI, clearing LOAD_DONE, LOAD_ERR, WORD_CNT and the length; CORE_RST_F drops to 0 on the same edge.
- Arithmetic: the address add wraps modulo 2^ADDR_W. LEN is compared as unsigned 16-bit.
- Reset mid-load: returns to IDLE immediately with the core held in reset. Already-written IM contents are left as is.

Test Plan:
- Reset, then START, stream 00 02 | 12 34 56 78 | 9A BC DE F0 -> two IM_WE pulses: addr 0 data 0x12345678, addr 1 data 0x9ABCDEF0. LOAD_DONE=1 and CORE_RST_F=1 one cycle after the second write; WORD_CNT=2.
- Same image with BYTE_VALID toggled 1/0 every cycle -> identical writes and final state; no byte is lost or duplicated.
- Header 00 00 -> DONE with no IM_WE pulses; CORE_RST_F rises.
- Header 04 01 (1025 > MAX_WORDS) -> LOAD_ERR=1, BYTE_READY=0, CORE_RST_F=0, no writes. A subsequent START plus valid image -> normal load.
- Assert RST after the 6th data byte of a 3-word load -> immediately IDLE, all outputs 0. Restart with the full image -> 3 writes at addresses 0..2.
- START pulsed during DATA -> ignored, load completes. START in DONE -> CORE_RST_F drops to 0, reload succeeds. With BASE_ADDR=0xFFFF, a 2-word image writes to 0xFFFF then 0x0000.
